// File: rtl/arty_boot_pkg.sv
// Shared types and helpers for the Arty board boot/mode sequencer.
//   boot_state_t   : sequencer state encoding, also driven to the LEDs
//   db_cycles_calc : debounce stability window in clk cycles
//   cnt_width      : counter width able to hold 0..n-1
package arty_boot_pkg;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_HOLD      = 3'd1,
        S_RUN       = 3'd2,
        S_QUIESCE   = 3'd3,
        S_DEBUG     = 3'd4
    } boot_state_t;

    function automatic int unsigned db_cycles_calc(input int unsigned clk_freq_mhz,
                                                   input int unsigned debounce_us);
        return clk_freq_mhz * debounce_us;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/boot_debounce.sv
// One-bit 2-flop synchronizer plus debounce counter.
// The debounced register itself lives in the parent so that its next value can
// feed other registered outputs in the same cycle.
//   clk, rst_n : clock, async active-low reset
//   din        : raw asynchronous pin
//   cur        : debounced value currently held by the parent
//   nxt        : debounced value the parent must load at this edge
module boot_debounce
    import arty_boot_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic cur,
    output logic nxt
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // For a single bit, "synced value changed while differing" means it now
    // equals the held value, so the equality test also covers glitch restart.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        nxt   = cur;
        if (sync2_q == cur) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            nxt   = sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/arty_boot_ctrl.sv
// Board-level reset and mode sequencer between the Arty pins/MMCM and the SoC.
// Holds the SoC in reset until MMCM lock plus a fixed stretch, and moves between
// normal execution and UART debug mode with the core quiesced first.
//   clk, rst_n               : clock, async active-low reset
//   mmcm_locked              : MMCM lock (asynchronous)
//   sw_in, btn_in            : raw switches ([0] debug req, [1] core en) / buttons ([0] soft rst)
//   uart_host_writing/reading: debug UART busy flags from the SoC
//   soc_rst, core_en, uart_debug_en : registered SoC controls
//   sw_db, btn_db            : debounced switches / buttons
//   state                    : current sequencer state for LEDs
module arty_boot_ctrl
    import arty_boot_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ    = 50,
    parameter int unsigned DEBOUNCE_US     = 5000,
    parameter int unsigned RST_HOLD_CYCLES = 1024,
    parameter int unsigned QUIESCE_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mmcm_locked,
    input  logic [3:0] sw_in,
    input  logic [3:0] btn_in,
    input  logic       uart_host_writing,
    input  logic       uart_host_reading,
    output logic       soc_rst,
    output logic       core_en,
    output logic       uart_debug_en,
    output logic [3:0] sw_db,
    output logic [3:0] btn_db,
    output logic [2:0] state
);

    localparam int unsigned DB_CYCLES = db_cycles_calc(CLK_FREQ_MHZ, DEBOUNCE_US);
    localparam int unsigned HOLD_W    = cnt_width(RST_HOLD_CYCLES);
    localparam int unsigned QUI_W     = cnt_width(QUIESCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [QUI_W-1:0]  QUI_LAST  = QUI_W'(QUIESCE_CYCLES - 1);

    logic              lock_s1, lock_s2;
    logic [7:0]        raw, db_q, db_next;
    logic              dbg_prev, btn0_prev;
    logic              btn0_rise, dbg_rise, dbg_fall;
    boot_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [QUI_W-1:0]  qui_cnt;
    logic              soc_rst_q, core_en_q, uart_dbg_q;

    assign raw = {btn_in, sw_in};

    for (genvar i = 0; i < 8; i++) begin : g_db
        boot_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (raw[i]),
            .cur  (db_q[i]),
            .nxt  (db_next[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1   <= 1'b0;
            lock_s2   <= 1'b0;
            db_q      <= '0;
            dbg_prev  <= 1'b0;
            btn0_prev <= 1'b0;
        end else begin
            lock_s1   <= mmcm_locked;
            lock_s2   <= lock_s1;
            db_q      <= db_next;
            dbg_prev  <= db_q[0];
            btn0_prev <= db_q[4];
        end
    end

    assign sw_db     = db_q[3:0];
    assign btn_db    = db_q[7:4];
    assign btn0_rise = db_q[4] & ~btn0_prev;
    assign dbg_rise  = db_q[0] & ~dbg_prev;
    assign dbg_fall  = ~db_q[0] & dbg_prev;

    always_comb begin
        state_d = state_q;
        if (!lock_s2) begin
            state_d = S_WAIT_LOCK;
        end else if (btn0_rise && (state_q != S_WAIT_LOCK)) begin
            // Soft reset; in S_DEBUG this deliberately ignores UART busy.
            state_d = S_HOLD;
        end else begin
            unique case (state_q)
                S_WAIT_LOCK: state_d = S_HOLD;
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) state_d = db_q[0] ? S_DEBUG : S_RUN;
                end
                S_RUN: begin
                    if (dbg_rise) state_d = S_QUIESCE;
                end
                S_QUIESCE: begin
                    if (dbg_fall)                state_d = S_RUN;
                    else if (qui_cnt == QUI_LAST) state_d = S_DEBUG;
                end
                S_DEBUG: begin
                    if (!db_q[0] && !uart_host_writing && !uart_host_reading) state_d = S_HOLD;
                end
                default: state_d = S_WAIT_LOCK;
            endcase
        end
    end

    // Counters only advance while staying in their state; any entry (including a
    // soft-reset re-entry of S_HOLD) starts them from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_LOCK;
            hold_cnt   <= '0;
            qui_cnt    <= '0;
            soc_rst_q  <= 1'b1;
            core_en_q  <= 1'b0;
            uart_dbg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt   <= (state_q == S_HOLD && state_d == S_HOLD && !btn0_rise)
                          ? hold_cnt + HOLD_W'(1) : '0;
            qui_cnt    <= (state_q == S_QUIESCE && state_d == S_QUIESCE)
                          ? qui_cnt + QUI_W'(1) : '0;
            soc_rst_q  <= (state_d == S_WAIT_LOCK) || (state_d == S_HOLD);
            core_en_q  <= (state_d == S_RUN) && db_next[1];
            uart_dbg_q <= (state_d == S_DEBUG);
        end
    end

    assign soc_rst       = soc_rst_q;
    assign core_en       = core_en_q;
    assign uart_debug_en = uart_dbg_q;
    assign state         = state_q;

endmodule
